// File: rtl/lt24_cmd_pkg.sv
// rtl/lt24_cmd_pkg.sv - LT24 command codes, setup length and pixel writer FSM states
package lt24_cmd_pkg;

    localparam logic [7:0] CMD_COLUMN_ADDR  = 8'h2A;
    localparam logic [7:0] CMD_PAGE_ADDR    = 8'h2B;
    localparam logic [7:0] CMD_MEMORY_WRITE = 8'h2C;

    // Window setup: 3 commands + 8 address parameters.
    localparam int SETUP_WORDS = 11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP_LOW  = 3'd1,
        ST_SETUP_HIGH = 3'd2,
        ST_DATA_LOW   = 3'd3,
        ST_DATA_HIGH  = 3'd4
    } state_e;

endpackage

// File: rtl/lt24_bus_cycle.sv
// rtl/lt24_bus_cycle.sv - one 8080-style LT24 bus write with programmable strobe timing
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   start_i           load rs_i/data_i and begin a write (accepted on any cycle,
//                     including the final high cycle of the previous write)
//   rs_i, data_i      register-select and data word for the write
//   wr_n_o            write strobe: low WR_LOW_CYCLES, then high WR_HIGH_CYCLES
//   rs_o, data_o      held stable from the first low cycle through the rising edge
//   cs_n_o            low while writes are back-to-back, high once the bus goes idle
//   low_done_o        last low cycle of the current write
//   done_o            last high cycle of the current write
module lt24_bus_cycle #(
    parameter int WR_LOW_CYCLES  = 1,
    parameter int WR_HIGH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic        rs_i,
    input  logic [15:0] data_i,
    output logic        wr_n_o,
    output logic        rs_o,
    output logic [15:0] data_o,
    output logic        cs_n_o,
    output logic        low_done_o,
    output logic        done_o
);

    localparam logic [7:0] LOW_LAST  = 8'(WR_LOW_CYCLES - 1);
    localparam logic [7:0] HIGH_LAST = 8'(WR_HIGH_CYCLES - 1);

    logic        busy_q;
    logic        high_q;
    logic [7:0]  cnt_q;
    logic        wr_n_q;
    logic        rs_q;
    logic [15:0] data_q;
    logic        cs_n_q;

    assign low_done_o = busy_q && !high_q && (cnt_q == LOW_LAST);
    assign done_o     = busy_q &&  high_q && (cnt_q == HIGH_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            high_q <= 1'b0;
            cnt_q  <= 8'd0;
            wr_n_q <= 1'b1;
            rs_q   <= 1'b0;
            data_q <= 16'h0000;
            cs_n_q <= 1'b1;
        end else if (start_i) begin
            busy_q <= 1'b1;
            high_q <= 1'b0;
            cnt_q  <= 8'd0;
            wr_n_q <= 1'b0;
            cs_n_q <= 1'b0;
            rs_q   <= rs_i;
            data_q <= data_i;
        end else if (busy_q) begin
            if (!high_q) begin
                if (low_done_o) begin
                    high_q <= 1'b1;
                    cnt_q  <= 8'd0;
                    wr_n_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end else begin
                if (done_o) begin
                    // No follow-on write: release the bus. RS/data keep their
                    // last value, which is harmless with CS_n high.
                    busy_q <= 1'b0;
                    high_q <= 1'b0;
                    cnt_q  <= 8'd0;
                    cs_n_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign wr_n_o = wr_n_q;
    assign rs_o   = rs_q;
    assign data_o = data_q;
    assign cs_n_o = cs_n_q;

endmodule

// File: rtl/lt24_pixel_writer.sv
// rtl/lt24_pixel_writer.sv - addressed-pixel sink that drives LT24 (ILI9341) write cycles
//
// Ports:
//   clock, reset             system clock, asynchronous active-high reset
//   displayReady             panel init complete; gates pixel acceptance
//   xAddr, yAddr, pixelData  addressed RGB565 pixel, sampled only on acceptance
//   pixelWrite, pixelReady   pixel handshake (accept when both high at a clock edge)
//   LT24Wr_n, LT24Rd_n       write strobe / read strobe (read unused, held high)
//   LT24CS_n, LT24RS         chip select / command(0)-data(1) select
//   LT24Data                 16-bit bus data
//
// A pixel that continues raster order after the previous one is sent as a
// single data write; anything else first re-programs the column/page window
// and issues a memory-write command.
module lt24_pixel_writer
    import lt24_cmd_pkg::*;
#(
    parameter int WIDTH          = 240,
    parameter int HEIGHT         = 320,
    parameter int WR_LOW_CYCLES  = 1,
    parameter int WR_HIGH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        displayReady,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic [15:0] LT24Data
);

    localparam logic [8:0] X_LIM = 9'(WIDTH);
    localparam logic [9:0] Y_LIM = 10'(HEIGHT);
    localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
    localparam logic [8:0] Y_MAX = 9'(HEIGHT - 1);
    localparam logic [3:0] LAST_SETUP = 4'(SETUP_WORDS - 1);

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [7:0]  x_q;
    logic [8:0]  y_q;
    logic [15:0] pix_q;
    logic [7:0]  ex_q;
    logic [8:0]  ey_q;
    logic        stream_valid_q;

    logic        accept;
    logic        in_range;
    logic        hit;
    logic [3:0]  nidx;
    logic        sw_rs;
    logic [15:0] sw_data;
    logic        start;
    logic        start_rs;
    logic [15:0] start_data;
    logic        bus_low_done;
    logic        bus_done;

    assign pixelReady = (state_q == ST_IDLE) && displayReady;
    assign accept     = pixelWrite && pixelReady;
    assign in_range   = ({1'b0, xAddr} < X_LIM) && ({1'b0, yAddr} < Y_LIM);
    assign hit        = stream_valid_q && (xAddr == ex_q) && (yAddr == ey_q);
    assign nidx       = idx_q + 4'd1;
    assign LT24Rd_n   = 1'b1;

    // Window setup word for the index that follows the one just finished.
    // Index 0 (column command) is issued straight from IDLE.
    always_comb begin
        sw_rs   = 1'b1;
        sw_data = 16'h0000;
        case (nidx)
            4'd1:    sw_data = 16'h0000;
            4'd2:    sw_data = {8'h00, x_q};
            4'd3:    sw_data = 16'h0000;
            4'd4:    sw_data = 16'(WIDTH - 1);
            4'd5:    begin sw_rs = 1'b0; sw_data = {8'h00, CMD_PAGE_ADDR}; end
            4'd6:    sw_data = {15'h0000, y_q[8]};
            4'd7:    sw_data = {8'h00, y_q[7:0]};
            4'd8:    sw_data = 16'((HEIGHT - 1) >> 8);
            4'd9:    sw_data = 16'((HEIGHT - 1) & 255);
            4'd10:   begin sw_rs = 1'b0; sw_data = {8'h00, CMD_MEMORY_WRITE}; end
            default: begin sw_rs = 1'b0; sw_data = 16'h0000; end
        endcase
    end

    // Writes are chained on the done cycle so there is no idle gap between words.
    always_comb begin
        start      = 1'b0;
        start_rs   = 1'b0;
        start_data = 16'h0000;
        if (state_q == ST_IDLE && accept && in_range) begin
            start = 1'b1;
            if (hit) begin
                start_rs   = 1'b1;
                start_data = pixelData;
            end else begin
                start_rs   = 1'b0;
                start_data = {8'h00, CMD_COLUMN_ADDR};
            end
        end else if (state_q == ST_SETUP_HIGH && bus_done) begin
            start = 1'b1;
            if (idx_q == LAST_SETUP) begin
                start_rs   = 1'b1;
                start_data = pix_q;
            end else begin
                start_rs   = sw_rs;
                start_data = sw_data;
            end
        end
    end

    lt24_bus_cycle #(
        .WR_LOW_CYCLES  (WR_LOW_CYCLES),
        .WR_HIGH_CYCLES (WR_HIGH_CYCLES)
    ) u_bus (
        .clock      (clock),
        .reset      (reset),
        .start_i    (start),
        .rs_i       (start_rs),
        .data_i     (start_data),
        .wr_n_o     (LT24Wr_n),
        .rs_o       (LT24RS),
        .data_o     (LT24Data),
        .cs_n_o     (LT24CS_n),
        .low_done_o (bus_low_done),
        .done_o     (bus_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= 4'd0;
            x_q            <= 8'd0;
            y_q            <= 9'd0;
            pix_q          <= 16'h0000;
            ex_q           <= 8'd0;
            ey_q           <= 9'd0;
            stream_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_range) begin
                            x_q   <= xAddr;
                            y_q   <= yAddr;
                            pix_q <= pixelData;
                            if (hit) begin
                                state_q <= ST_DATA_LOW;
                            end else begin
                                idx_q   <= 4'd0;
                                state_q <= ST_SETUP_LOW;
                            end
                        end else begin
                            // Dropped pixel: panel address counter is no longer trusted.
                            stream_valid_q <= 1'b0;
                        end
                    end
                end
                ST_SETUP_LOW: begin
                    if (bus_low_done) state_q <= ST_SETUP_HIGH;
                end
                ST_SETUP_HIGH: begin
                    if (bus_done) begin
                        if (idx_q == LAST_SETUP) begin
                            state_q <= ST_DATA_LOW;
                        end else begin
                            idx_q   <= nidx;
                            state_q <= ST_SETUP_LOW;
                        end
                    end
                end
                ST_DATA_LOW: begin
                    if (bus_low_done) state_q <= ST_DATA_HIGH;
                end
                ST_DATA_HIGH: begin
                    if (bus_done) begin
                        state_q        <= ST_IDLE;
                        stream_valid_q <= 1'b1;
                        if (x_q == X_MAX) begin
                            ex_q <= 8'd0;
                            ey_q <= (y_q == Y_MAX) ? 9'd0 : y_q + 9'd1;
                        end else begin
                            ex_q <= x_q + 8'd1;
                            ey_q <= y_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Losing displayReady forces the next pixel through a full window setup.
            if (!displayReady) stream_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lt24_pixel_writer.sv
// tb/tb_lt24_pixel_writer.sv - self-checking bench for lt24_pixel_writer
module tb_lt24_pixel_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        displayReady;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic        LT24Wr_n;
    logic        LT24Rd_n;
    logic        LT24CS_n;
    logic        LT24RS;
    logic [15:0] LT24Data;

    int tests = 0;
    int fails = 0;

    logic [16:0] wlog[$];
    logic [16:0] exp_q[$];
    logic        prev_wr = 1'b1;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] d;
        bit          setup;
        bit          drop;
    } vec_t;

    vec_t vecs[14];

    lt24_pixel_writer dut (
        .clock        (clock),
        .reset        (reset),
        .displayReady (displayReady),
        .xAddr        (xAddr),
        .yAddr        (yAddr),
        .pixelData    (pixelData),
        .pixelWrite   (pixelWrite),
        .pixelReady   (pixelReady),
        .LT24Wr_n     (LT24Wr_n),
        .LT24Rd_n     (LT24Rd_n),
        .LT24CS_n     (LT24CS_n),
        .LT24RS       (LT24RS),
        .LT24Data     (LT24Data)
    );

    always #5 clock = ~clock;

    // Log {RS, Data} at every Wr_n rising edge, as the panel would capture it.
    always @(negedge clock) begin
        if (prev_wr == 1'b0 && LT24Wr_n == 1'b1) wlog.push_back({LT24RS, LT24Data});
        prev_wr = LT24Wr_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic build_exp(input int x, input int y, input logic [15:0] d, input bit setup);
        exp_q.delete();
        if (setup) begin
            exp_q.push_back({1'b0, 16'h002A});
            exp_q.push_back({1'b1, 16'h0000});
            exp_q.push_back({1'b1, 16'(x)});
            exp_q.push_back({1'b1, 16'h0000});
            exp_q.push_back({1'b1, 16'h00EF});
            exp_q.push_back({1'b0, 16'h002B});
            exp_q.push_back({1'b1, 16'(y / 256)});
            exp_q.push_back({1'b1, 16'(y % 256)});
            exp_q.push_back({1'b1, 16'h0001});
            exp_q.push_back({1'b1, 16'h003F});
            exp_q.push_back({1'b0, 16'h002C});
        end
        exp_q.push_back({1'b1, d});
    endtask

    task automatic compare_log(input string tag);
        check($sformatf("%s nwrites", tag), wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            check($sformatf("%s word%0d", tag, i), {15'd0, wlog[i]}, {15'd0, exp_q[i]});
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic accept_pixel(input int x, input int y, input logic [15:0] d);
        int n = 0;
        while (!pixelReady && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!pixelReady) begin
            tests++;
            fails++;
            $display("FAIL accept timeout: pixelReady=0 after %0d cycles, want 1", n);
        end
        xAddr      = 8'(x);
        yAddr      = 9'(y);
        pixelData  = d;
        pixelWrite = 1'b1;
        @(posedge clock);
        @(negedge clock);
        pixelWrite = 1'b0;
        xAddr      = 8'hAA;
        yAddr      = 9'h155;
        pixelData  = 16'hDEAD;
    endtask

    task automatic wait_ready(output int low);
        low = 0;
        while (!pixelReady && low < 200) begin
            low++;
            @(negedge clock);
        end
    endtask

    initial begin
        int low;
        int cnt;

        vecs[0]  = '{0,   0,   16'hF800, 1'b1, 1'b0};
        vecs[1]  = '{1,   0,   16'h07E0, 1'b0, 1'b0};
        vecs[2]  = '{2,   0,   16'h001F, 1'b0, 1'b0};
        vecs[3]  = '{239, 0,   16'h1234, 1'b1, 1'b0};
        vecs[4]  = '{0,   1,   16'h5678, 1'b0, 1'b0};
        vecs[5]  = '{239, 319, 16'h9ABC, 1'b1, 1'b0};
        vecs[6]  = '{0,   0,   16'hDEF0, 1'b0, 1'b0};
        vecs[7]  = '{5,   5,   16'h1111, 1'b1, 1'b0};
        vecs[8]  = '{100, 200, 16'h2222, 1'b1, 1'b0};
        vecs[9]  = '{240, 0,   16'h3333, 1'b0, 1'b1};
        vecs[10] = '{101, 200, 16'h4444, 1'b1, 1'b0};
        vecs[11] = '{0,   320, 16'h5555, 1'b0, 1'b1};
        vecs[12] = '{0,   0,   16'h6666, 1'b1, 1'b0};
        vecs[13] = '{1,   0,   16'h7777, 1'b0, 1'b0};

        reset        = 1'b1;
        displayReady = 1'b0;
        pixelWrite   = 1'b0;
        xAddr        = 8'd0;
        yAddr        = 9'd0;
        pixelData    = 16'h0000;
        repeat (3) @(negedge clock);
        check("reset pixelReady", {31'd0, pixelReady}, 32'd0);
        check("reset Wr_n",       {31'd0, LT24Wr_n},   32'd1);
        check("reset Rd_n",       {31'd0, LT24Rd_n},   32'd1);
        check("reset CS_n",       {31'd0, LT24CS_n},   32'd1);
        check("reset RS",         {31'd0, LT24RS},     32'd0);
        check("reset Data",       {16'd0, LT24Data},   32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("no ready without displayReady", {31'd0, pixelReady}, 32'd0);
        displayReady = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 14; v++) begin
            wlog.delete();
            accept_pixel(vecs[v].x, vecs[v].y, vecs[v].d);
            wait_ready(low);
            if (vecs[v].drop) repeat (3) @(negedge clock);
            check($sformatf("v%0d ready latency", v), low,
                  vecs[v].setup ? 24 : (vecs[v].drop ? 0 : 2));
            if (vecs[v].drop) exp_q.delete();
            else build_exp(vecs[v].x, vecs[v].y, vecs[v].d, vecs[v].setup);
            compare_log($sformatf("v%0d", v));
            check($sformatf("v%0d CS_n idle", v), {31'd0, LT24CS_n}, 32'd1);
            if (v == 8 && wlog.size() == 12) begin
                check("jump x param", {15'd0, wlog[2]}, {15'd0, 17'h10064});
                check("jump y hi",    {15'd0, wlog[6]}, {15'd0, 17'h10000});
                check("jump y lo",    {15'd0, wlog[7]}, {15'd0, 17'h100C8});
            end
        end

        // Asynchronous reset while SETUP word 4 is on the bus.
        wlog.delete();
        accept_pixel(50, 60, 16'hAAAA);
        repeat (8) @(negedge clock);
        check("word4 Wr_n low", {31'd0, LT24Wr_n}, 32'd0);
        check("words before reset", wlog.size(), 4);
        #2 reset = 1'b1;
        #1;
        check("async reset Wr_n", {31'd0, LT24Wr_n}, 32'd1);
        check("async reset CS_n", {31'd0, LT24CS_n}, 32'd1);
        check("async reset RS",   {31'd0, LT24RS},   32'd0);
        check("async reset Data", {16'd0, LT24Data}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        wlog.delete();
        accept_pixel(51, 60, 16'hBBBB);
        wait_ready(low);
        check("post-reset latency", low, 24);
        build_exp(51, 60, 16'hBBBB, 1'b1);
        compare_log("post-reset");

        // displayReady dropped during a streamed DATA write.
        wlog.delete();
        accept_pixel(52, 60, 16'hCCCC);
        displayReady = 1'b0;
        xAddr        = 8'd7;
        yAddr        = 9'd7;
        pixelData    = 16'h0BAD;
        pixelWrite   = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (pixelReady) cnt++;
        end
        check("ready while disabled", cnt, 0);
        check("disabled Wr_n", {31'd0, LT24Wr_n}, 32'd1);
        check("disabled CS_n", {31'd0, LT24CS_n}, 32'd1);
        build_exp(52, 60, 16'hCCCC, 1'b0);
        compare_log("drop-mid-data");
        pixelWrite   = 1'b0;
        displayReady = 1'b1;
        @(negedge clock);
        wlog.delete();
        accept_pixel(53, 60, 16'hDDDD);
        wait_ready(low);
        check("re-enable latency", low, 24);
        build_exp(53, 60, 16'hDDDD, 1'b1);
        compare_log("re-enable");
        check("Rd_n constant", {31'd0, LT24Rd_n}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lt24_pixel_writer.md
Name: lt24_pixel_writer

Overview:
- Responder (sink) end of the team's LT24 pixel interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady).
- Accepts one addressed pixel per handshake and emits ILI9341-style 8080 write cycles on the LT24 bus.
- Issues a window-setup command sequence only when the address breaks raster order; otherwise streams data only.
- Sits between pattern/user logic and the panel, after the panel power-up/init sequencer, which drives displayReady.

Parameters:
- WIDTH, 240, panel columns; x range 0..WIDTH-1.
- HEIGHT, 320, panel rows; y range 0..HEIGHT-1.
- WR_LOW_CYCLES, 1, clocks LT24Wr_n is held low per bus write (>=1).
- WR_HIGH_CYCLES, 1, clocks LT24Wr_n is held high per bus write (>=1). Data is captured by the panel on the Wr_n rising edge.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- displayReady  in  1  panel init complete; gates acceptance.
- xAddr  in  8  pixel column.
- yAddr  in  9  pixel row.
- pixelData  in  16  RGB565 pixel.
- pixelWrite  in  1  pixel valid.
- pixelReady  out  1  block can accept a pixel this cycle.
- LT24Wr_n  out  1  write strobe, active low.
- LT24Rd_n  out  1  read strobe; constant 1.
- LT24CS_n  out  1  chip select, active low.
- LT24RS  out  1  0 = command, 1 = parameter/data.
- LT24Data  out  16  bus data.

Behaviour:
- Reset (async, active-high) values: pixelReady=0, LT24Wr_n=1, LT24Rd_n=1, LT24CS_n=1, LT24RS=0, LT24Data=0, streamValid=0, FSM=IDLE.
- Handshake:
  - pixelReady = (FSM==IDLE) && displayReady.
  - A pixel is accepted on the rising clock edge where pixelWrite && pixelReady. xAddr, yAddr and pixelData are registered at that edge.
- Range check: if x>=WIDTH or y>=HEIGHT, the pixel is dropped. There is no bus activity, streamValid is cleared, and pixelReady returns on the next cycle.
- Stream decision:
  - The block keeps an expected-next (ex, ey): x+1; at WIDTH-1 it wraps to x=0, y+1; at (WIDTH-1, HEIGHT-1) it wraps to (0, 0).
  - If streamValid && (x,y)==(ex,ey), the block goes to DATA only.
  - Otherwise it runs SETUP then DATA.
- SETUP sequence: 11 bus writes, in order.
  1. RS=0: 0x002A.
  2. RS=1: 0x0000, x, 0x0000, WIDTH-1.
  3. RS=0: 0x002B.
  4. RS=1: {15'b0, y[8]}, {8'b0, y[7:0]}, (HEIGHT-1)>>8, (HEIGHT-1)&0xFF.
  5. RS=0: 0x002C.
- DATA: one bus write with RS=1 and LT24Data=pixelData. After it, streamValid=1 and (ex, ey) are updated.
- Bus write timing:
  - LT24CS_n, LT24RS and LT24Data are set in the first low cycle.
  - LT24Wr_n is held 0 for WR_LOW_CYCLES, then 1 for WR_HIGH_CYCLES.
  - LT24Data and LT24RS stay stable through the Wr_n rising edge.
  - LT24CS_n returns to 1 in IDLE.
- FSM states: IDLE -> (SETUP_LOW <-> SETUP_HIGH, stepping a 4-bit index 0..10) -> DATA_LOW -> DATA_HIGH -> IDLE.
- Latency and throughput at defaults:
  - Stream pixel: accept at edge 0, Wr_n low in cycle 1, high in cycle 2, pixelReady=1 in cycle 3. Throughput is 1 pixel per 3 clocks.
  - Setup pixel: 12 writes, so pixelReady returns 24 clocks after accept.
  - General cycles per write: WR_LOW_CYCLES + WR_HIGH_CYCLES.
- displayReady deassertion:
  - An in-flight sequence completes.
  - streamValid is cleared, so the first pixel after re-assertion always runs SETUP.
- Reset mid-sequence: the bus is forced to its idle reset values immediately. No partial-write completion.
- pixelWrite high while pixelReady=0 is ignored, with no error. Inputs are not sampled outside acceptance edges.

Decomposition:
- Package lt24_cmd_pkg holds:
  - CMD_COLUMN_ADDR=8'h2A, CMD_PAGE_ADDR=8'h2B, CMD_MEMORY_WRITE=8'h2C.
  - SETUP_WORDS=11.
  - The FSM state enum.
- Sub-module lt24_bus_cycle: given start, rs and data, drives Wr_n/RS/Data/CS_n timing per WR_LOW_CYCLES/WR_HIGH_CYCLES, and pulses done on the last high cycle. The top-level FSM sequences words through it.

Test Plan:
1. Reset, then displayReady=1, pixel (0,0,0xF800) -> 12 Wr_n rising edges:
   - RS/Data = 0/002A, 1/0000, 1/0000, 1/0000, 1/00EF, 0/002B, 1/0000, 1/0000, 1/0001, 1/003F, 0/002C, 1/F800.
   - pixelReady returns 24 clocks after accept.
2. Pixels (1,0) then (2,0) streamed back-to-back -> only data writes, RS=1, one pixelReady every 3 clocks, no 0x2A/0x2B.
3. Sequence (239,0) then (0,1), then (239,319) then (0,0) -> both wrap transitions stream without SETUP.
4. Jump (5,5) to (100,200) -> SETUP with x param 0x0064, y params 0x0000, 0x00C8, then data.
5. Pixel (240,0) or (0,320) -> no Wr_n activity, pixelReady back after 1 cycle; next in-range pixel runs SETUP.
6. Reset asserted during SETUP word 4, and displayReady dropped mid-DATA:
   - Reset case: Wr_n=1 and CS_n=1 asynchronously.
   - displayReady case: the write completes, pixelReady stays 0, and the next pixel after re-enable runs SETUP.
